// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter: FSM encoding,
// fault/NOP instruction value and the default memory word-address width.
package imem_pkg;

  localparam int WORD_AW_DEF = 18;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles loader bytes into a little-endian 32-bit word; lane 0 is bits [7:0].
// word_done flags the cycle in which the fourth byte of a word is accepted.
module imem_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  lane_q;
  logic [31:0] asm_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= 2'd0;
      asm_q  <= '0;
    end else if (accept) begin
      asm_q[{lane_q, 3'b000} +: 8] <= data;
      lane_q                       <= lane_q + 2'd1;
    end
  end

  assign word      = asm_q;
  assign word_done = accept && (lane_q == 2'd3);

endmodule

// File: rtl/imem_arbiter.sv
// Single-port arbiter for the instruction memory: CPU fetch (read-only) shares
// the array with a byte-streaming program loader, which has priority.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int WORD_AW = WORD_AW_DEF,
  parameter int LEN_W   = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               f_req,
  input  logic [ADDR_W-1:0]  f_addr,
  output logic               f_gnt,
  output logic               f_rvalid,
  output logic [31:0]        f_inst,
  output logic               f_fault,
  input  logic               l_start,
  input  logic [ADDR_W-1:0]  l_base,
  input  logic [LEN_W-1:0]   l_len,
  input  logic               l_valid,
  input  logic [7:0]         l_byte,
  output logic               l_ready,
  output logic               l_busy,
  output logic               l_done,
  output logic               m_en,
  output logic               m_we,
  output logic [WORD_AW-1:0] m_addr,
  output logic [31:0]        m_wdata,
  input  logic [31:0]        m_rdata
);

  state_t              state_q, state_d;
  logic [WORD_AW-1:0]  waddr_q;
  logic [LEN_W-1:0]    wcnt_q;
  logic                done_q;
  logic                rvalid_q, fault_q, rd_pend_q;
  logic [31:0]         inst_q;

  logic                accept, word_done, f_aligned;
  logic                start_load, start_empty, last_word;
  logic [31:0]         packed_word;

  // Upper address bits alias and the loader base is word-aligned by truncation.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{f_addr[ADDR_W-1:WORD_AW+2],
                              l_base[ADDR_W-1:WORD_AW+2], l_base[1:0]};

  assign l_ready     = (state_q == COLLECT);
  assign l_busy      = (state_q != IDLE);
  assign l_done      = done_q;
  assign accept      = l_valid && l_ready;
  assign f_aligned   = (f_addr[1:0] == 2'b00);
  assign f_gnt       = f_req && (state_q == IDLE) && !l_start;
  assign start_load  = (state_q == IDLE) && l_start && (l_len != '0);
  assign start_empty = (state_q == IDLE) && l_start && (l_len == '0);
  assign last_word   = (state_q == WRITE) && (wcnt_q == LEN_W'(1));

  imem_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .data      (l_byte),
    .word      (packed_word),
    .word_done (word_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block is defaulted first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = f_addr[WORD_AW+1:2];
    m_wdata = packed_word;
    unique case (state_q)
      IDLE: begin
        if (start_load)
          state_d = COLLECT;
        else if (f_gnt && f_aligned)
          m_en = 1'b1;
      end
      COLLECT: begin
        if (word_done) state_d = WRITE;
      end
      WRITE: begin
        m_en    = 1'b1;
        m_we    = 1'b1;
        m_addr  = waddr_q;
        state_d = last_word ? IDLE : COLLECT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Session bookkeeping: word address wraps modulo the array size.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr_q <= '0;
      wcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= start_empty || last_word;
      if (start_load) begin
        waddr_q <= l_base[WORD_AW+1:2];
        wcnt_q  <= l_len;
      end else if (state_q == WRITE) begin
        waddr_q <= waddr_q + 1'b1;
        wcnt_q  <= wcnt_q - 1'b1;
      end
    end
  end

  // Fetch response: aligned reads forward m_rdata directly in the result
  // cycle; inst_q remembers the last result so f_inst holds between grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q  <= 1'b0;
      fault_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      inst_q    <= NOP_INST;
    end else begin
      rvalid_q  <= f_gnt;
      fault_q   <= f_gnt && !f_aligned;
      rd_pend_q <= f_gnt && f_aligned;
      if (f_gnt && !f_aligned)
        inst_q <= NOP_INST;
      else if (rd_pend_q)
        inst_q <= m_rdata;
    end
  end

  assign f_rvalid = rvalid_q;
  assign f_fault  = fault_q;
  assign f_inst   = rd_pend_q ? m_rdata : inst_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a synchronous-read memory model.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt, f_rvalid, f_fault;
  logic [31:0] f_inst;
  logic        l_start;
  logic [31:0] l_base;
  logic [17:0] l_len;
  logic        l_valid;
  logic [7:0]  l_byte;
  logic        l_ready, l_busy, l_done;
  logic        m_en, m_we;
  logic [17:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  int passed = 0;
  int total  = 0;
  int done_cnt = 0;
  logic [17:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] mem [0:262143];

  imem_arbiter dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_inst(f_inst), .f_fault(f_fault),
    .l_start(l_start), .l_base(l_base), .l_len(l_len), .l_valid(l_valid),
    .l_byte(l_byte), .l_ready(l_ready), .l_busy(l_busy), .l_done(l_done),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_en && !m_we) m_rdata <= mem[m_addr];
    if (m_en && m_we) begin
      mem[m_addr] <= m_wdata;
      wr_addr.push_back(m_addr);
      wr_data.push_back(m_wdata);
    end
    if (l_done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic start_load(input logic [31:0] base, input logic [17:0] len);
    @(negedge clk); l_start = 1'b1; l_base = base; l_len = len;
    @(negedge clk); l_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk); l_valid = 1'b1; l_byte = b;
    while (!l_ready && n < 8) begin @(negedge clk); n++; end
    if (!l_ready) begin
      total++;
      $display("FAIL send_byte: l_ready got 0 want 1 within 8 cycles");
    end
    @(posedge clk); #1 l_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
  endtask

  task automatic fetch_check(input string name, input logic [31:0] addr,
                             input logic [31:0] exp_inst, input logic exp_fault);
    @(negedge clk); f_req = 1'b1; f_addr = addr; #1;
    total++;
    if (f_gnt !== 1'b1) $display("FAIL %s gnt: got %b want 1", name, f_gnt);
    else passed++;
    @(negedge clk); f_req = 1'b0;
    total++;
    if ({f_rvalid, f_fault, f_inst} !== {1'b1, exp_fault, exp_inst})
      $display("FAIL %s result: got rvalid=%b fault=%b inst=%h want 1 %b %h",
               name, f_rvalid, f_fault, f_inst, exp_fault, exp_inst);
    else passed++;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({f_rvalid, f_fault, l_busy, l_done, l_ready, m_en, f_inst} !== 38'h0)
      $display("FAIL reset: got rvalid=%b fault=%b busy=%b done=%b ready=%b m_en=%b inst=%h want all 0",
               f_rvalid, f_fault, l_busy, l_done, l_ready, m_en, f_inst);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_reset_midstream;
    int n0 = wr_addr.size();
    start_load(32'h100, 18'd2);
    send_byte(8'h13);
    send_byte(8'h00);
    @(negedge clk); rst = 1'b1; #1;
    total++;
    if ({l_busy, l_ready, l_done} !== 3'b000)
      $display("FAIL reset_mid: got busy=%b ready=%b done=%b want 000", l_busy, l_ready, l_done);
    else passed++;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (wr_addr.size() != n0)
      $display("FAIL reset_mid writes: got %0d want %0d", wr_addr.size(), n0);
    else passed++;
    fetch_check("reset_mid_fetch", 32'h100, 32'hCAFEF00D, 1'b0);
  endtask

  task automatic test_aligned_fetch;
    @(negedge clk); f_req = 1'b1; f_addr = 32'h14; #1;
    total++;
    if ({f_gnt, m_en, m_we, m_addr} !== {3'b110, 18'd5})
      $display("FAIL aligned req: got gnt=%b en=%b we=%b addr=%0d want 1 1 0 5", f_gnt, m_en, m_we, m_addr);
    else passed++;
    @(negedge clk); f_req = 1'b0;
    total++;
    if ({f_rvalid, f_fault, f_inst} !== {2'b10, 32'h00500093})
      $display("FAIL aligned resp: got rvalid=%b fault=%b inst=%h want 1 0 00500093", f_rvalid, f_fault, f_inst);
    else passed++;
    @(negedge clk);
    total++;
    if ({f_rvalid, f_inst} !== {1'b0, 32'h00500093})
      $display("FAIL idle hold: got rvalid=%b inst=%h want 0 00500093", f_rvalid, f_inst);
    else passed++;
  endtask

  task automatic test_misaligned_fetch;
    @(negedge clk); f_req = 1'b1; f_addr = 32'h16; #1;
    total++;
    if ({f_gnt, m_en} !== 2'b10)
      $display("FAIL misaligned req: got gnt=%b en=%b want 1 0", f_gnt, m_en);
    else passed++;
    @(negedge clk); f_req = 1'b0;
    total++;
    if ({f_rvalid, f_fault, f_inst} !== {2'b11, 32'h0})
      $display("FAIL misaligned resp: got rvalid=%b fault=%b inst=%h want 1 1 0", f_rvalid, f_fault, f_inst);
    else passed++;
  endtask

  task automatic test_load_two;
    int n0 = wr_addr.size();
    int d0 = done_cnt;
    start_load(32'h100, 18'd2);
    send_word(32'h00000013);
    send_word(32'h00500093);
    repeat (3) @(negedge clk);
    total++;
    if (wr_addr.size() != n0 + 2)
      $display("FAIL load2 count: got %0d want %0d", wr_addr.size() - n0, 2);
    else if ({wr_addr[n0], wr_data[n0], wr_addr[n0+1], wr_data[n0+1]} !==
             {18'd64, 32'h00000013, 18'd65, 32'h00500093})
      $display("FAIL load2 writes: got %0d:%h %0d:%h want 64:00000013 65:00500093",
               wr_addr[n0], wr_data[n0], wr_addr[n0+1], wr_data[n0+1]);
    else passed++;
    total++;
    if (done_cnt - d0 != 1 || l_busy !== 1'b0)
      $display("FAIL load2 done: got pulses=%0d busy=%b want 1 0", done_cnt - d0, l_busy);
    else passed++;
    fetch_check("load2_fetch104", 32'h104, 32'h00500093, 1'b0);
    fetch_check("load2_fetch100", 32'h100, 32'h00000013, 1'b0);
  endtask

  task automatic test_contention;
    int bad = 0;
    logic [31:0] w = 32'h11223344;
    @(negedge clk);
    l_start = 1'b1; l_base = 32'h20; l_len = 18'd1; f_req = 1'b1; f_addr = 32'h20; #1;
    total++;
    if (f_gnt !== 1'b0) $display("FAIL start_wins: got gnt=%b want 0", f_gnt);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); l_start = 1'b0; l_valid = 1'b1; l_byte = w[i*8 +: 8]; #1;
      if (f_gnt !== 1'b0 || f_rvalid !== 1'b0 || l_ready !== 1'b1 || m_en !== 1'b0) bad++;
    end
    @(negedge clk); l_valid = 1'b0; #1;
    total++;
    if ({m_en, m_we, m_addr, m_wdata, f_gnt, f_rvalid} !== {2'b11, 18'd8, w, 2'b00})
      $display("FAIL contention write: got en=%b we=%b addr=%0d data=%h gnt=%b rvalid=%b want 1 1 8 %h 0 0",
               m_en, m_we, m_addr, m_wdata, f_gnt, f_rvalid, w);
    else passed++;
    total++;
    if (bad != 0) $display("FAIL contention collect: got %0d bad cycles want 0", bad);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({f_gnt, f_rvalid, l_busy, l_done} !== 4'b1001)
      $display("FAIL contention regrant: got gnt=%b rvalid=%b busy=%b done=%b want 1 0 0 1",
               f_gnt, f_rvalid, l_busy, l_done);
    else passed++;
    @(negedge clk); f_req = 1'b0;
    total++;
    if ({f_rvalid, f_fault, f_inst} !== {2'b10, w})
      $display("FAIL contention read: got rvalid=%b fault=%b inst=%h want 1 0 %h", f_rvalid, f_fault, f_inst, w);
    else passed++;
  endtask

  task automatic test_back_to_back;
    @(negedge clk); f_req = 1'b1; f_addr = 32'h14;
    @(negedge clk); f_addr = 32'h16;
    total++;
    if ({f_rvalid, f_fault, f_inst} !== {2'b10, 32'h00500093})
      $display("FAIL b2b first: got %b %b %h want 1 0 00500093", f_rvalid, f_fault, f_inst);
    else passed++;
    @(negedge clk); f_addr = 32'h20;
    total++;
    if ({f_rvalid, f_fault, f_inst} !== {2'b11, 32'h0})
      $display("FAIL b2b second: got %b %b %h want 1 1 00000000", f_rvalid, f_fault, f_inst);
    else passed++;
    @(negedge clk); f_req = 1'b0;
    total++;
    if ({f_rvalid, f_fault, f_inst} !== {2'b10, 32'h11223344})
      $display("FAIL b2b third: got %b %b %h want 1 0 11223344", f_rvalid, f_fault, f_inst);
    else passed++;
    @(negedge clk);
    total++;
    if ({f_rvalid, f_inst} !== {1'b0, 32'h11223344})
      $display("FAIL b2b hold: got %b %h want 0 11223344", f_rvalid, f_inst);
    else passed++;
  endtask

  task automatic test_len_zero;
    int n0 = wr_addr.size();
    @(negedge clk); l_start = 1'b1; l_base = 32'h40; l_len = 18'd0;
    @(negedge clk); l_start = 1'b0;
    total++;
    if ({l_done, l_busy} !== 2'b10)
      $display("FAIL len0 pulse: got done=%b busy=%b want 1 0", l_done, l_busy);
    else passed++;
    @(negedge clk);
    total++;
    if (l_done !== 1'b0 || wr_addr.size() != n0)
      $display("FAIL len0 after: got done=%b writes=%0d want 0 0", l_done, wr_addr.size() - n0);
    else passed++;
  endtask

  task automatic test_wrap;
    int n0 = wr_addr.size();
    start_load(32'h000F_FFFC, 18'd2);
    send_word(32'hAAAA0001);
    send_word(32'hBBBB0002);
    repeat (3) @(negedge clk);
    total++;
    if (wr_addr.size() != n0 + 2)
      $display("FAIL wrap count: got %0d want 2", wr_addr.size() - n0);
    else if ({wr_addr[n0], wr_addr[n0+1]} !== {18'h3FFFF, 18'h0})
      $display("FAIL wrap addr: got %h %h want 3ffff 00000", wr_addr[n0], wr_addr[n0+1]);
    else passed++;
    fetch_check("wrap_fetch0", 32'h0, 32'hBBBB0002, 1'b0);
    fetch_check("alias_fetch", 32'h0100_0000, 32'hBBBB0002, 1'b0);
    fetch_check("top_fetch", 32'h000F_FFFC, 32'hAAAA0001, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 32'h0;
    mem[5]  = 32'h00500093;
    mem[64] = 32'hCAFEF00D;
    m_rdata = 32'h0;
    rst = 1'b1; f_req = 1'b0; f_addr = '0; l_start = 1'b0; l_base = '0;
    l_len = '0; l_valid = 1'b0; l_byte = '0;
    test_reset;
    test_reset_midstream;
    test_aligned_fetch;
    test_misaligned_fetch;
    test_load_two;
    test_contention;
    test_back_to_back;
    test_len_zero;
    test_wrap;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Single-port arbiter and sequencer in front of the instruction memory array (word-addressed, 2^18 x 32-bit, synchronous read).
- Shares the array between the CPU fetch path (read-only) and a program loader that streams bytes in and assembles them into little-endian words.
- The loader session has priority and stalls fetch.
- Fetch reads complete with a fixed 1-cycle latency.
- Sits between the core's PC/fetch logic and the memory macro.

Parameters:
- ADDR_W, 32, fetch/loader byte-address width
- WORD_AW, 18, word-address width into the memory (byte address bits [WORD_AW+1:2])
- LEN_W, 18, width of the loader word-count field

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- f_req  in  1  fetch request, sampled each cycle
- f_addr  in  ADDR_W  fetch byte address (PC)
- f_gnt  out  1  request accepted this cycle (combinational)
- f_rvalid  out  1  registered; fetch data valid
- f_inst  out  32  fetched instruction, valid when f_rvalid
- f_fault  out  1  with f_rvalid: address misaligned (addr[1:0] != 0)
- l_start  in  1  pulse: begin a load session
- l_base  in  ADDR_W  session start byte address, sampled at l_start
- l_len  in  LEN_W  number of words to load, sampled at l_start
- l_valid  in  1  loader byte valid
- l_byte  in  8  loader byte
- l_ready  out  1  byte accepted when l_valid && l_ready
- l_busy  out  1  load session active
- l_done  out  1  one-cycle pulse after the last word is written
- m_en  out  1  memory access enable
- m_we  out  1  memory write enable
- m_addr  out  WORD_AW  memory word address
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data, valid the cycle after m_en && !m_we

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - f_rvalid, f_fault, l_busy, l_done, l_ready = 0.
  - f_inst = 0; byte counter = 0; word counter = 0; assembly register = 0.
- States:
  - IDLE: fetch serviced. l_start with l_len != 0 latches the base word address (l_base[WORD_AW+1:2]; l_base[1:0] ignored) and the length, then moves to COLLECT. l_start with l_len == 0 pulses l_done next cycle and stays in IDLE.
  - COLLECT: l_ready=1; l_busy=1. Each accepted byte goes into byte lane k (k = byte counter 0..3, lane 0 = bits [7:0]). The 4th byte moves to WRITE.
  - WRITE: l_ready=0. Drives m_en=1, m_we=1, m_addr=current word address, m_wdata=the assembled word (4th byte merged combinationally, no extra cycle). Word address increments and wraps modulo 2^WORD_AW. Word counter decrements. At zero: state goes to IDLE, l_busy drops, l_done pulses the next cycle. Otherwise back to COLLECT.
- Fetch (IDLE only):
  - f_gnt = f_req && state==IDLE && !l_start. l_start wins any simultaneous fetch.
  - Aligned grant: m_en=1, m_we=0, m_addr=f_addr[WORD_AW+1:2]. Next cycle: f_rvalid=1, f_inst=m_rdata, f_fault=0.
  - Misaligned grant: m_en=0. Next cycle: f_rvalid=1, f_inst=0, f_fault=1.
  - f_addr bits above WORD_AW+1 are ignored (aliasing).
  - Back-to-back requests give one result per cycle.
  - No grant: f_rvalid=0 next cycle; f_inst holds its last value.
- Loader backpressure: l_valid gaps in COLLECT are allowed; the partial word is held indefinitely.
- l_start while busy: ignored.
- Reset mid-session: session aborted, partial word discarded, no write issued.
- m_en is 0 in COLLECT.

Decomposition:
- Shared package (imem_pkg):
  - state encoding: IDLE=2'd0, COLLECT=2'd1, WRITE=2'd2
  - NOP/fault instruction constant (32'h0)
  - WORD_AW default
- One natural sub-module, imem_byte_packer: byte counter, lane assembly register, word-complete strobe.

Test Plan:
- Reset mid-stream: assert rst after 2 bytes of a load → l_busy=0, no m_we pulse; a later fetch of that word returns the preloaded value.
- Aligned fetch: memory preloaded with word 5 = 32'h00500093; f_req=1, f_addr=32'h14 → f_gnt=1, m_addr=5, m_we=0; next cycle f_rvalid=1, f_inst=32'h00500093, f_fault=0.
- Misaligned fetch: f_addr=32'h16 → m_en=0; next cycle f_rvalid=1, f_fault=1, f_inst=0.
- Load 2 words: l_start with l_base=32'h100, l_len=2; bytes 13,00,00,00,93,00,50,00 → m_we writes 32'h00000013 at m_addr=64 and 32'h00500093 at m_addr=65; l_done pulses once; fetch of 32'h104 then returns 32'h00500093.
- Contention: f_req held high during a session → f_gnt=0 and f_rvalid=0 throughout; the first grant comes the cycle after the state returns to IDLE.
- Edge cases:
  - l_len=0 → l_done pulses the next cycle and no write is issued.
  - l_base at the top word (word 2^18-1) with l_len=2 → the second write lands at m_addr=0 (wrap).
  - l_start together with f_req → l_start wins and f_gnt=0.
